// File: rtl/regfile_writeback.sv
// regfile_writeback: collects ALU and load results, queues each source in its own
// small FIFO and drains them round-robin onto the register file's single write port.
// PENDING flags every register that still has a queued or in-flight write.

module regfile_writeback_fifo #(
    parameter int N     = 32,
    parameter int SIZE  = 64,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_valid,
    input  logic [$clog2(N)-1:0] push_rd,
    input  logic [SIZE-1:0]      push_data,
    input  logic                 pop,
    output logic                 ready,
    output logic                 not_empty,
    output logic [$clog2(N)-1:0] head_rd,
    output logic [SIZE-1:0]      head_data,
    output logic [N-1:0]         pend
);
    localparam int RW = $clog2(N);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [RW-1:0]   rd_q   [DEPTH];
    logic [RW-1:0]   rd_d   [DEPTH];
    logic [SIZE-1:0] data_q [DEPTH];
    logic [SIZE-1:0] data_d [DEPTH];
    logic [AW-1:0]   wp_q, wp_d;
    logic [AW-1:0]   rp_q, rp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push;

    // Ready comes from the registered count only; a same-cycle pop never frees a slot.
    assign ready     = rst_n && (cnt_q < FULL);
    assign not_empty = (cnt_q != '0);
    assign head_rd   = rd_q[rp_q];
    assign head_data = data_q[rp_q];
    // Writes to x0 finish the handshake but are dropped here.
    assign push      = push_valid && ready && (push_rd != '0);

    // Next storage, pointer and occupancy values for one push and/or one pop.
    always_comb begin
        rd_d   = rd_q;
        data_d = data_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        if (push) begin
            rd_d[wp_q]   = push_rd;
            data_d[wp_q] = push_data;
            wp_d         = wp_q + AW'(1);
        end
        if (pop) begin
            rp_d = rp_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    // Mark the destination of every live entry, walking from the read pointer.
    always_comb begin
        pend = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < cnt_q) begin
                pend[rd_q[rp_q + AW'(k)]] = 1'b1;
            end
        end
    end

    // FIFO state registers; reset empties the queue immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                rd_q[k]   <= '0;
                data_q[k] <= '0;
            end
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q   <= rd_d;
            data_q <= data_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

module regfile_writeback #(
    parameter int N     = 32,
    parameter int SIZE  = 64,
    parameter int DEPTH = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 ALU_VALID,
    output logic                 ALU_READY,
    input  logic [$clog2(N)-1:0] ALU_RD,
    input  logic [SIZE-1:0]      ALU_DATA,
    input  logic                 MEM_VALID,
    output logic                 MEM_READY,
    input  logic [$clog2(N)-1:0] MEM_RD,
    input  logic [SIZE-1:0]      MEM_DATA,
    output logic                 WE,
    output logic [$clog2(N)-1:0] Rw,
    output logic [SIZE-1:0]      Din,
    output logic [N-1:0]         PENDING,
    output logic                 BUSY
);
    localparam int   RW      = $clog2(N);
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    logic            alu_ne, mem_ne;
    logic [RW-1:0]   alu_head_rd, mem_head_rd;
    logic [SIZE-1:0] alu_head_data, mem_head_data;
    logic [N-1:0]    alu_pend, mem_pend;
    logic            grant_alu, grant_mem;
    logic            last_grant_q, last_grant_d;
    logic            we_q, we_d;
    logic [RW-1:0]   rw_q, rw_d;
    logic [SIZE-1:0] din_q, din_d;

    regfile_writeback_fifo #(.N(N), .SIZE(SIZE), .DEPTH(DEPTH)) u_alu_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push_valid(ALU_VALID),
        .push_rd   (ALU_RD),
        .push_data (ALU_DATA),
        .pop       (grant_alu),
        .ready     (ALU_READY),
        .not_empty (alu_ne),
        .head_rd   (alu_head_rd),
        .head_data (alu_head_data),
        .pend      (alu_pend)
    );

    regfile_writeback_fifo #(.N(N), .SIZE(SIZE), .DEPTH(DEPTH)) u_mem_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push_valid(MEM_VALID),
        .push_rd   (MEM_RD),
        .push_data (MEM_DATA),
        .pop       (grant_mem),
        .ready     (MEM_READY),
        .not_empty (mem_ne),
        .head_rd   (mem_head_rd),
        .head_data (mem_head_data),
        .pend      (mem_pend)
    );

    // Round-robin grant: a lone non-empty FIFO wins, otherwise the one not served last.
    always_comb begin
        grant_alu = alu_ne && (!mem_ne || (last_grant_q == SRC_MEM));
        grant_mem = mem_ne && (!alu_ne || (last_grant_q == SRC_ALU));
    end

    // Output-stage next state: load the granted head, otherwise drop WE and hold Rw/Din.
    always_comb begin
        we_d         = grant_alu || grant_mem;
        rw_d         = rw_q;
        din_d        = din_q;
        last_grant_d = last_grant_q;
        if (grant_alu) begin
            rw_d         = alu_head_rd;
            din_d        = alu_head_data;
            last_grant_d = SRC_ALU;
        end else if (grant_mem) begin
            rw_d         = mem_head_rd;
            din_d        = mem_head_data;
            last_grant_d = SRC_MEM;
        end
    end

    // Pending mask covers both queues plus the write currently on the port; x0 never pends.
    always_comb begin
        PENDING = alu_pend | mem_pend;
        if (we_q) begin
            PENDING[rw_q] = 1'b1;
        end
        PENDING[0] = 1'b0;
    end

    // Registered write port and arbitration history.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            we_q         <= 1'b0;
            rw_q         <= '0;
            din_q        <= '0;
            last_grant_q <= SRC_ALU;
        end else begin
            we_q         <= we_d;
            rw_q         <= rw_d;
            din_q        <= din_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign WE   = we_q;
    assign Rw   = rw_q;
    assign Din  = din_q;
    assign BUSY = alu_ne || mem_ne || we_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Testbench for regfile_writeback: directed steps plus a short random burst, with a
// queue-based model of both producer FIFOs and the write port as scoreboard.
`timescale 1ns/1ps
module tb_regfile_writeback;
    localparam int N     = 32;
    localparam int SIZE  = 64;
    localparam int DEPTH = 2;
    localparam int RW    = $clog2(N);

    typedef struct packed {
        logic [RW-1:0]   rd;
        logic [SIZE-1:0] data;
    } beat_t;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            ALU_VALID = 1'b0;
    logic            ALU_READY;
    logic [RW-1:0]   ALU_RD = '0;
    logic [SIZE-1:0] ALU_DATA = '0;
    logic            MEM_VALID = 1'b0;
    logic            MEM_READY;
    logic [RW-1:0]   MEM_RD = '0;
    logic [SIZE-1:0] MEM_DATA = '0;
    logic            WE;
    logic [RW-1:0]   Rw;
    logic [SIZE-1:0] Din;
    logic [N-1:0]    PENDING;
    logic            BUSY;

    beat_t a_src[$];
    beat_t m_src[$];
    beat_t mq_a[$];
    beat_t mq_m[$];
    beat_t exp_q[$];
    int    rw_log[$];

    logic          m_last = 1'b0;
    logic          m_we = 1'b0;
    logic [RW-1:0] m_rw = '0;
    logic          m_ra, m_rm, m_ga, m_gm;
    beat_t         mon_e;
    int            we_run = 0;
    int            we_max = 0;
    int            m_acc = 0;
    int            m_stall_at = -1;
    int            n_chk = 0;
    int            n_fail = 0;
    int            rr_exp[8] = '{1, 11, 2, 12, 3, 13, 4, 14};
    int            mem_seen[$];

    always #5 CLK = ~CLK;

    regfile_writeback #(.N(N), .SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ALU_VALID(ALU_VALID),
        .ALU_READY(ALU_READY),
        .ALU_RD   (ALU_RD),
        .ALU_DATA (ALU_DATA),
        .MEM_VALID(MEM_VALID),
        .MEM_READY(MEM_READY),
        .MEM_RD   (MEM_RD),
        .MEM_DATA (MEM_DATA),
        .WE       (WE),
        .Rw       (Rw),
        .Din      (Din),
        .PENDING  (PENDING),
        .BUSY     (BUSY)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic [RW-1:0] rd, input logic [SIZE-1:0] data);
        beat_t b;
        b.rd   = rd;
        b.data = data;
        return b;
    endfunction

    function automatic logic [N-1:0] model_pending();
        logic [N-1:0] p;
        p = '0;
        foreach (mq_a[i]) p[mq_a[i].rd] = 1'b1;
        foreach (mq_m[i]) p[mq_m[i].rd] = 1'b1;
        if (m_we) p[m_rw] = 1'b1;
        return p;
    endfunction

    // Reference model: grant from the heads, then accept new beats using pre-edge fill levels.
    always @(posedge CLK) begin
        if (RST_N) begin
            m_ra = (mq_a.size() < DEPTH);
            m_rm = (mq_m.size() < DEPTH);
            m_ga = (mq_a.size() > 0) && ((mq_m.size() == 0) || m_last);
            m_gm = (mq_m.size() > 0) && ((mq_a.size() == 0) || !m_last);
            m_we = m_ga || m_gm;
            if (m_ga) begin
                exp_q.push_back(mq_a[0]);
                m_rw = mq_a[0].rd;
                void'(mq_a.pop_front());
                m_last = 1'b0;
            end else if (m_gm) begin
                exp_q.push_back(mq_m[0]);
                m_rw = mq_m[0].rd;
                void'(mq_m.pop_front());
                m_last = 1'b1;
            end
            if (ALU_VALID && m_ra && (ALU_RD != '0)) mq_a.push_back(mk(ALU_RD, ALU_DATA));
            if (MEM_VALID && m_rm && (MEM_RD != '0)) mq_m.push_back(mk(MEM_RD, MEM_DATA));
        end
    end

    always @(negedge RST_N) begin
        mq_a.delete();
        mq_m.delete();
        exp_q.delete();
        m_we   = 1'b0;
        m_rw   = '0;
        m_last = 1'b0;
    end

    // Scoreboard monitor on the falling edge.
    always @(negedge CLK) begin
        if (RST_N) begin
            check("we", WE, m_we);
            check("alu_ready", ALU_READY, (mq_a.size() < DEPTH));
            check("mem_ready", MEM_READY, (mq_m.size() < DEPTH));
            check("pending", PENDING, model_pending());
            check("busy", BUSY, (mq_a.size() > 0) || (mq_m.size() > 0) || m_we);
            if (WE === 1'b1) begin
                check("we_rw_nonzero", (Rw != '0), 1'b1);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", WE, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rw", Rw, mon_e.rd);
                    check("din", Din, mon_e.data);
                end
                rw_log.push_back(int'(Rw));
                we_run++;
                if (we_run > we_max) we_max = we_run;
            end else begin
                we_run = 0;
            end
        end
    end

    task automatic cycle();
        @(negedge CLK);
        #1;
        if (a_src.size() > 0) begin
            ALU_VALID = 1'b1;
            ALU_RD    = a_src[0].rd;
            ALU_DATA  = a_src[0].data;
            if (ALU_READY) void'(a_src.pop_front());
        end else begin
            ALU_VALID = 1'b0;
        end
        if (m_src.size() > 0) begin
            MEM_VALID = 1'b1;
            MEM_RD    = m_src[0].rd;
            MEM_DATA  = m_src[0].data;
            if (MEM_READY) begin
                void'(m_src.pop_front());
                m_acc++;
            end else if (m_stall_at < 0) begin
                m_stall_at = m_acc;
            end
        end else begin
            MEM_VALID = 1'b0;
        end
    endtask

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while ((a_src.size() > 0 || m_src.size() > 0 || ALU_VALID || MEM_VALID || BUSY)
                   && k < max_cycles);
        check("drain_busy", BUSY, 1'b0);
        check("drain_src_left", a_src.size() + m_src.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a valid ALU beat offered.
        RST_N     = 1'b0;
        ALU_VALID = 1'b1;
        ALU_RD    = RW'(3);
        ALU_DATA  = 64'h55;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_alu_ready", ALU_READY, 1'b0);
        check("rst_mem_ready", MEM_READY, 1'b0);
        check("rst_we", WE, 1'b0);
        check("rst_pending", PENDING, '0);
        check("rst_busy", BUSY, 1'b0);
        ALU_VALID = 1'b0;
        RST_N     = 1'b1;
        @(negedge CLK);
        #1;
        check("post_rst_alu_ready", ALU_READY, 1'b1);
        check("post_rst_mem_ready", MEM_READY, 1'b1);

        // x0 discard.
        a_src.push_back(mk(RW'(0), 64'h1234));
        cycle();
        check("x0_handshake_ready", ALU_READY, 1'b1);
        cycle();
        check("x0_we", WE, 1'b0);
        check("x0_busy", BUSY, 1'b0);
        check("x0_pending", PENDING, '0);
        cycle();
        check("x0_we_later", WE, 1'b0);

        // Single ALU write latency and PENDING window.
        a_src.push_back(mk(RW'(5), 64'hDEAD_BEEF));
        cycle();
        cycle();
        check("lat_we_t", WE, 1'b0);
        check("lat_pend5_t", PENDING[5], 1'b1);
        cycle();
        check("lat_we_t1", WE, 1'b1);
        check("lat_rw_t1", Rw, RW'(5));
        check("lat_din_t1", Din, 64'hDEAD_BEEF);
        check("lat_pend5_t1", PENDING[5], 1'b1);
        cycle();
        check("lat_we_t2", WE, 1'b0);
        check("lat_pend_t2", PENDING, '0);

        // One MEM write so the next contest starts with ALU.
        rw_log.delete();
        m_src.push_back(mk(RW'(7), 64'h7777));
        drain(20);
        check("mem1_count", rw_log.size(), 1);
        if (rw_log.size() > 0) check("mem1_rw", rw_log[0], 7);

        // Round-robin with both sources saturated.
        rw_log.delete();
        we_max = 0;
        for (int i = 1; i <= 4; i++) begin
            a_src.push_back(mk(RW'(i), 64'hA000_0000_0000_0000 | 64'(i)));
            m_src.push_back(mk(RW'(i + 10), 64'hB000_0000_0000_0000 | 64'(i + 10)));
        end
        drain(40);
        check("rr_count", rw_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < rw_log.size()) check($sformatf("rr_seq%0d", i), rw_log[i], rr_exp[i]);
        end
        check("rr_consecutive_we", we_max, 8);

        // Backpressure on MEM while ALU keeps competing.
        rw_log.delete();
        m_acc      = 0;
        m_stall_at = -1;
        for (int i = 1; i <= 6; i++) a_src.push_back(mk(RW'(i), 64'hC0 + 64'(i)));
        for (int i = 21; i <= 23; i++) m_src.push_back(mk(RW'(i), 64'hD00 + 64'(i)));
        drain(60);
        check("bp_stall_after", m_stall_at, 2);
        check("bp_mem_accepted", m_acc, 3);
        check("bp_total_writes", rw_log.size(), 9);
        mem_seen.delete();
        foreach (rw_log[i]) if (rw_log[i] >= 21) mem_seen.push_back(rw_log[i]);
        check("bp_mem_count", mem_seen.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < mem_seen.size()) check($sformatf("bp_mem_order%0d", i), mem_seen[i], 21 + i);
        end

        // Reset in the middle of queued traffic.
        for (int i = 1; i <= 4; i++) begin
            a_src.push_back(mk(RW'(i + 2), 64'hE0 + 64'(i)));
            m_src.push_back(mk(RW'(i + 16), 64'hF0 + 64'(i)));
        end
        repeat (3) cycle();
        check("pre_rst_we", WE, 1'b1);
        check("pre_rst_pending_nz", (PENDING != '0), 1'b1);
        a_src.delete();
        m_src.delete();
        ALU_VALID = 1'b0;
        MEM_VALID = 1'b0;
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_we", WE, 1'b0);
        check("mid_rst_pending", PENDING, '0);
        check("mid_rst_busy", BUSY, 1'b0);
        check("mid_rst_alu_ready", ALU_READY, 1'b0);
        check("mid_rst_mem_ready", MEM_READY, 1'b0);
        #4;
        RST_N = 1'b1;
        rw_log.delete();
        repeat (5) cycle();
        check("post_mid_rst_writes", rw_log.size(), 0);
        check("post_mid_rst_busy", BUSY, 1'b0);

        // Random mixed traffic, including x0 beats.
        for (int i = 0; i < 24; i++) begin
            a_src.push_back(mk(RW'($urandom_range(0, N - 1)), {$urandom, $urandom}));
            m_src.push_back(mk(RW'($urandom_range(0, N - 1)), {$urandom, $urandom}));
        end
        drain(300);
        check("rand_exp_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
